// File: rtl/pipelined_shifter.sv
// pipelined_shifter
//   Fully pipelined barrel shifter. There are SHW = log2(WIDTH) register
//   stages. Stage k shifts or rotates by 2^k when bit k of the amount is set.
//   Each stage carries valid, mode, the amount bits and a sticky lost flag
//   along with the data. Stall is global: while out_valid && !out_ready,
//   every stage holds.
//
// Ports
//   clk, rst_n     rising-edge clock, asynchronous active-low reset
//   in_valid       request present
//   in_ready       request accepted on an edge where in_valid && in_ready
//   in_rt          operand to shift
//   in_sh          immediate shift amount
//   in_rs          register shift amount (low SHW bits used)
//   in_reg_imm     amount source: 0 = in_sh, 1 = in_rs[SHW-1:0]
//   in_mode        000 SLL, 001 SRL, 010 SRA, 011 ROR, 100 ROL, others pass
//   out_valid      result present
//   out_ready      consumer accepts the result
//   out_data       shifted result
//   out_lost       a 1 bit was discarded by SLL/SRL/SRA
module pipelined_shifter #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_rt,
  input  logic [SHW-1:0]   in_sh,
  input  logic [WIDTH-1:0] in_rs,
  input  logic             in_reg_imm,
  input  logic [2:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_lost
);

  typedef enum logic [2:0] {
    MODE_SLL = 3'b000,
    MODE_SRL = 3'b001,
    MODE_SRA = 3'b010,
    MODE_ROR = 3'b011,
    MODE_ROL = 3'b100
  } shiftMode_t;

  logic [WIDTH-1:0] stData  [SHW];
  logic [2:0]       stMode  [SHW];
  logic [SHW-1:0]   stAmt   [SHW];
  logic             stLost  [SHW];
  logic             stValid [SHW];

  logic             stall;
  logic [SHW-1:0]   inAmt;
  logic             unusedTail;

  // One stage's operation: returns {lostBit, data}. The SRA fill is the
  // current MSB, which every earlier SRA stage has preserved, so it always
  // equals the sign of the original operand.
  function automatic logic [WIDTH:0] stageOp(input logic [WIDTH-1:0] d,
                                             input logic [2:0] m,
                                             input logic en,
                                             input int k);
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] lowMask;
    logic             l;
    int               s;
    s       = 1 << k;
    r       = d;
    l       = 1'b0;
    lowMask = ~({WIDTH{1'b1}} << s);
    if (en) begin
      case (m)
        MODE_SLL: begin
          r = d << s;
          l = |(d >> (WIDTH - s));
        end
        MODE_SRL: begin
          r = d >> s;
          l = |(d & lowMask);
        end
        MODE_SRA: begin
          r = $signed(d) >>> s;
          l = |(d & lowMask);
        end
        MODE_ROR: r = (d >> s) | (d << (WIDTH - s));
        MODE_ROL: r = (d << s) | (d >> (WIDTH - s));
        default: ;
      endcase
    end
    return {l, r};
  endfunction

  assign stall     = out_valid && !out_ready;
  assign in_ready  = !stall;

  assign out_valid = stValid[SHW-1];
  assign out_data  = stData[SHW-1];
  assign out_lost  = stLost[SHW-1];

  // Pass-through modes force a zero amount so no stage touches the data.
  always_comb begin
    inAmt = in_reg_imm ? in_rs[SHW-1:0] : in_sh;
    if (in_mode > MODE_ROL) inAmt = '0;
  end

  // Last-stage mode/amount and the upper register-amount bits are not needed.
  assign unusedTail = ^{stAmt[SHW-1], stMode[SHW-1], in_rs[WIDTH-1:SHW]};

  for (genvar k = 0; k < SHW; k++) begin : gStage
    logic [WIDTH-1:0] srcData;
    logic [2:0]       srcMode;
    logic [SHW-1:0]   srcAmt;
    logic             srcLost;
    logic             srcValid;
    logic [WIDTH:0]   opResult;

    if (k == 0) begin : gFirst
      assign srcData  = in_rt;
      assign srcMode  = in_mode;
      assign srcAmt   = inAmt;
      assign srcLost  = 1'b0;
      assign srcValid = in_valid;
    end else begin : gNext
      assign srcData  = stData[k-1];
      assign srcMode  = stMode[k-1];
      assign srcAmt   = stAmt[k-1];
      assign srcLost  = stLost[k-1];
      assign srcValid = stValid[k-1];
    end

    assign opResult = stageOp(srcData, srcMode, srcAmt[k], k);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stValid[k] <= 1'b0;
        stData[k]  <= '0;
        stMode[k]  <= '0;
        stAmt[k]   <= '0;
        stLost[k]  <= 1'b0;
      end else if (!stall) begin
        stValid[k] <= srcValid;
        stData[k]  <= opResult[WIDTH-1:0];
        stMode[k]  <= srcMode;
        stAmt[k]   <= srcAmt;
        stLost[k]  <= srcLost | opResult[WIDTH];
      end
    end
  end

endmodule
